wormhole_switch_allocator: RTL and testbench

Parametrised successor to the per-router switch-allocation stage. It arbitrates input buffers onto output ports with per-outport round-robin fairness, wormhole packet locking (an outport stays with one input from head to tail flit), and per-outport, per-VC downstream credit counters. It sits between the VC-allocation stage and the crossbar: `out_sel`/`out_valid` drive crossbar select/enable, and `grant` drives buffer pop.

---
 rtl/wormhole_switch_allocator.sv | 173 +++++++++++++++++
 tb/tb_wormhole_switch_allocator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_switch_allocator.sv
// Switch allocator: per-outport round-robin arbitration with wormhole locking
// and per-outport, per-VC downstream credit tracking.
module wormhole_switch_allocator #(
    parameter int unsigned NUM_IN      = 8,
    parameter int unsigned NUM_OUT     = 5,
    parameter int unsigned NUM_VCS     = 2,
    parameter int unsigned BUFFER_SIZE = 8,
    localparam int unsigned IW = $clog2(NUM_IN),
    localparam int unsigned OW = $clog2(NUM_OUT),
    localparam int unsigned VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned CW = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                    clk,
    input  logic                                    n_rst,
    input  logic [NUM_IN-1:0]                       req,
    input  logic [NUM_IN-1:0][OW-1:0]               req_outport,
    input  logic [NUM_IN-1:0][VW-1:0]               req_vc,
    input  logic [NUM_IN-1:0]                       req_tail,
    input  logic [NUM_OUT-1:0][NUM_VCS-1:0]         credit_return,
    output logic [NUM_IN-1:0]                       grant,
    output logic [NUM_OUT-1:0]                      out_valid,
    output logic [NUM_OUT-1:0][IW-1:0]              out_sel,
    output logic [NUM_OUT-1:0][NUM_VCS-1:0][CW-1:0] credits,
    output logic [NUM_OUT-1:0]                      locked,
    output logic                                    err_credit_ovf
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                                r_state [NUM_OUT];
    state_t                                w_state [NUM_OUT];
    logic [NUM_OUT-1:0][IW-1:0]            r_owner, w_owner;
    logic [NUM_OUT-1:0][IW-1:0]            r_rr_ptr, w_rr_ptr;
    logic [NUM_OUT-1:0][VW-1:0]            r_lvc, w_lvc;
    logic [NUM_OUT-1:0][NUM_VCS-1:0][CW-1:0] r_credits, w_credits;
    logic                                  r_err, w_err;

    logic [NUM_IN-1:0]                     w_grant;
    logic [NUM_OUT-1:0]                    w_out_valid;
    logic [NUM_OUT-1:0][IW-1:0]            w_out_sel;
    logic [NUM_OUT-1:0][VW-1:0]            w_gvc;

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                r_state[o]  <= S_IDLE;
                r_rr_ptr[o] <= IW'(NUM_IN - 1);
                for (int v = 0; v < NUM_VCS; v++) begin
                    r_credits[o][v] <= CW'(BUFFER_SIZE);
                end
            end
            r_owner <= '0;
            r_lvc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_rr_ptr  <= w_rr_ptr;
            r_lvc     <= w_lvc;
            r_credits <= w_credits;
            r_err     <= w_err;
        end
    end

    // Arbitration, FSM next state and credit next state
    always_comb begin
        logic            hit;
        logic            ok;
        logic            dec;
        logic            inc;
        logic [IW-1:0]   idx;
        logic [IW-1:0]   win;
        logic [VW-1:0]   wvc;

        w_grant     = '0;
        w_out_valid = '0;
        w_out_sel   = '0;
        w_gvc       = '0;
        w_state     = r_state;
        w_owner     = r_owner;
        w_rr_ptr    = r_rr_ptr;
        w_lvc       = r_lvc;
        w_credits   = r_credits;
        w_err       = r_err;
        hit         = 1'b0;
        ok          = 1'b0;
        dec         = 1'b0;
        inc         = 1'b0;
        idx         = '0;
        win         = '0;
        wvc         = '0;

        for (int o = 0; o < NUM_OUT; o++) begin
            hit = 1'b0;
            win = '0;
            wvc = '0;
            if (r_state[o] == S_IDLE) begin
                // First eligible input after the last winner, wrapping modulo NUM_IN
                for (int k = 1; k <= NUM_IN; k++) begin
                    idx = IW'((32'(r_rr_ptr[o]) + 32'(k)) % NUM_IN);
                    ok  = 1'b0;
                    for (int v = 0; v < NUM_VCS; v++) begin
                        if (32'(req_vc[idx]) == 32'(v) && r_credits[o][v] != '0) begin
                            ok = 1'b1;
                        end
                    end
                    if (!hit && ok && req[idx] && 32'(req_outport[idx]) == 32'(o)) begin
                        hit = 1'b1;
                        win = idx;
                        wvc = req_vc[idx];
                    end
                end
            end else begin
                win = r_owner[o];
                wvc = r_lvc[o];
                hit = req[win] && (32'(req_outport[win]) == 32'(o)) && (r_credits[o][wvc] != '0);
            end

            if (hit) begin
                w_grant[win]   = 1'b1;
                w_out_valid[o] = 1'b1;
                w_out_sel[o]   = win;
                w_gvc[o]       = wvc;
                if (r_state[o] == S_IDLE) begin
                    w_rr_ptr[o] = win;
                    if (!req_tail[win]) begin
                        w_state[o] = S_LOCKED;
                        w_owner[o] = win;
                        w_lvc[o]   = wvc;
                    end
                end else if (req_tail[win]) begin
                    w_state[o] = S_IDLE;
                end
            end
        end

        // A simultaneous grant and return cancel out; a return into a full counter is flagged
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                dec = w_out_valid[o] && (32'(w_gvc[o]) == 32'(v));
                inc = credit_return[o][v];
                if (dec && !inc) begin
                    w_credits[o][v] = r_credits[o][v] - CW'(1);
                end else if (inc && !dec) begin
                    if (r_credits[o][v] == CW'(BUFFER_SIZE)) begin
                        w_err = 1'b1;
                    end else begin
                        w_credits[o][v] = r_credits[o][v] + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        locked = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            locked[o] = (r_state[o] == S_LOCKED);
        end
    end

    // Crossbar controls are forced quiet while reset is held
    assign grant          = n_rst ? w_grant     : '0;
    assign out_valid      = n_rst ? w_out_valid : '0;
    assign out_sel        = n_rst ? w_out_sel   : '0;
    assign credits        = r_credits;
    assign err_credit_ovf = r_err;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Scoreboard bench for wormhole_switch_allocator: directed scenarios plus random
// traffic, checked against a distance-based behavioural arbitration model.
module tb_wormhole_switch_allocator;

    localparam int NI = 8;
    localparam int NO = 5;
    localparam int NV = 2;
    localparam int BS = 8;
    localparam int IW = 3;
    localparam int OW = 3;
    localparam int VW = 1;
    localparam int CW = 4;

    logic                          clk;
    logic                          n_rst;
    logic [NI-1:0]                 req;
    logic [NI-1:0][OW-1:0]         req_outport;
    logic [NI-1:0][VW-1:0]         req_vc;
    logic [NI-1:0]                 req_tail;
    logic [NO-1:0][NV-1:0]         credit_return;
    logic [NI-1:0]                 grant;
    logic [NO-1:0]                 out_valid;
    logic [NO-1:0][IW-1:0]         out_sel;
    logic [NO-1:0][NV-1:0][CW-1:0] credits;
    logic [NO-1:0]                 locked;
    logic                          err_credit_ovf;

    typedef struct {
        logic [NI-1:0]                 grant;
        logic [NO-1:0]                 valid;
        logic [NO-1:0][IW-1:0]         sel;
        logic [NO-1:0]                 lck;
        logic [NO-1:0][NV-1:0][CW-1:0] cred;
        logic                          err;
        bit                            dir;
        logic [NI-1:0]                 dgrant;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: holder -1 means the outport is free
    int m_hold [NO];
    int m_hvc  [NO];
    int m_last [NO];
    int m_cred [NO][NV];
    bit m_err;

    wormhole_switch_allocator #(
        .NUM_IN(NI), .NUM_OUT(NO), .NUM_VCS(NV), .BUFFER_SIZE(BS)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_outport(req_outport),
        .req_vc(req_vc), .req_tail(req_tail), .credit_return(credit_return),
        .grant(grant), .out_valid(out_valid), .out_sel(out_sel),
        .credits(credits), .locked(locked), .err_credit_ovf(err_credit_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_hold[o] = -1;
            m_hvc[o]  = 0;
            m_last[o] = NI - 1;
            for (int v = 0; v < NV; v++) m_cred[o][v] = BS;
        end
        m_err = 1'b0;
    endtask

    task automatic clr();
        req = '0; req_outport = '0; req_vc = '0; req_tail = '0; credit_return = '0;
    endtask

    task automatic set_in(input int i, input int op, input int vc, input bit tl);
        req[i] = 1'b1; req_outport[i] = OW'(op); req_vc[i] = VW'(vc); req_tail[i] = tl;
    endtask

    // Predict this cycle's outputs from current inputs, queue them, then advance the model
    task automatic step(input bit dir, input logic [NI-1:0] dg);
        exp_t e;
        int   nh [NO];
        int   nv [NO];
        int   nl [NO];
        int   nc [NO][NV];
        bit   ne;
        bit   used [NO][NV];
        if (!n_rst) model_reset();
        e.grant = '0; e.valid = '0; e.sel = '0; e.lck = '0; e.cred = '0;
        e.err = m_err; e.dir = dir; e.dgrant = dg;
        for (int o = 0; o < NO; o++) begin
            e.lck[o] = (m_hold[o] >= 0);
            for (int v = 0; v < NV; v++) begin
                e.cred[o][v] = CW'(m_cred[o][v]);
                used[o][v]   = 1'b0;
            end
        end
        nh = m_hold; nv = m_hvc; nl = m_last; nc = m_cred; ne = m_err;
        if (n_rst) begin
            for (int o = 0; o < NO; o++) begin
                int w;
                int wv;
                w = -1; wv = 0;
                if (m_hold[o] < 0) begin
                    int bestd;
                    bestd = NI;
                    for (int i = 0; i < NI; i++) begin
                        if (req[i] && int'(req_outport[i]) == o && m_cred[o][req_vc[i]] > 0) begin
                            int d;
                            d = (i - m_last[o] - 1 + NI) % NI;
                            if (d < bestd) begin bestd = d; w = i; wv = int'(req_vc[i]); end
                        end
                    end
                    if (w >= 0) begin
                        nl[o] = w;
                        if (!req_tail[w]) begin nh[o] = w; nv[o] = wv; end
                    end
                end else if (req[m_hold[o]] && int'(req_outport[m_hold[o]]) == o &&
                             m_cred[o][m_hvc[o]] > 0) begin
                    w = m_hold[o]; wv = m_hvc[o];
                    if (req_tail[w]) nh[o] = -1;
                end
                if (w >= 0) begin
                    e.grant[w] = 1'b1; e.valid[o] = 1'b1; e.sel[o] = IW'(w); used[o][wv] = 1'b1;
                end
            end
            for (int o = 0; o < NO; o++) begin
                for (int v = 0; v < NV; v++) begin
                    if (used[o][v] && !credit_return[o][v]) nc[o][v] = m_cred[o][v] - 1;
                    else if (!used[o][v] && credit_return[o][v]) begin
                        if (m_cred[o][v] == BS) ne = 1'b1;
                        else nc[o][v] = m_cred[o][v] + 1;
                    end
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        m_hold = nh; m_hvc = nv; m_last = nl; m_cred = nc; m_err = ne;
    endtask

    // Monitor: outputs are presented every cycle, so one queued record is consumed per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("grant",     64'(grant),          64'(e.grant));
                check("out_valid", 64'(out_valid),      64'(e.valid));
                check("out_sel",   64'(out_sel),        64'(e.sel));
                check("locked",    64'(locked),         64'(e.lck));
                check("credits",   64'(credits),        64'(e.cred));
                check("err_ovf",   64'(err_credit_ovf), 64'(e.err));
                if (e.dir) check("dir_grant", 64'(grant), 64'(e.dgrant));
            end
        end
    end

    initial begin
        int dest [NI];
        n_rst = 1'b0;
        clr();
        req = '1;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with every input requesting
        step(1'b1, 8'h00);

        // First priority after reset, then rotation
        n_rst = 1'b1;
        clr(); set_in(0, 2, 0, 1'b1); set_in(3, 2, 0, 1'b1);
        step(1'b1, 8'h01);
        step(1'b1, 8'h08);

        // Round-robin among 1, 4, 6 with returns matching every grant
        clr(); set_in(1, 0, 0, 1'b1); set_in(4, 0, 0, 1'b1); set_in(6, 0, 0, 1'b1);
        credit_return[0][0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 8'h02);
            step(1'b1, 8'h10);
            step(1'b1, 8'h40);
        end

        // Wormhole lock with a two-cycle owner bubble
        clr(); set_in(2, 1, 0, 1'b0); set_in(5, 1, 1, 1'b1);
        step(1'b1, 8'h04);
        set_in(2, 1, 1, 1'b0);
        step(1'b1, 8'h04);
        req[2] = 1'b0;
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        set_in(2, 1, 1, 1'b0);
        step(1'b1, 8'h04);
        set_in(2, 1, 1, 1'b1);
        step(1'b1, 8'h04);
        req[2] = 1'b0;
        step(1'b1, 8'h20);

        // Credit exhaustion on (3,1) and single-credit refill without bypass
        clr(); set_in(0, 3, 1, 1'b0);
        for (int k = 0; k < BS; k++) step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        credit_return[3][1] = 1'b1;
        step(1'b1, 8'h00);
        credit_return[3][1] = 1'b0;
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        credit_return[3][1] = 1'b1;
        step(1'b1, 8'h00);
        credit_return[3][1] = 1'b0;
        req_tail[0] = 1'b1;
        step(1'b1, 8'h01);
        clr();
        credit_return[3][1] = 1'b1;
        for (int k = 0; k < BS; k++) step(1'b0, 8'h00);

        // Simultaneous grant/return, then overflow which must stick
        clr(); set_in(4, 4, 0, 1'b1); credit_return[4][0] = 1'b1;
        step(1'b1, 8'h10);
        clr(); credit_return[2][1] = 1'b1;
        step(1'b1, 8'h00);
        clr();
        for (int k = 0; k < 3; k++) step(1'b1, 8'h00);

        // Reset during flit 2 of a 4-flit packet
        clr(); set_in(1, 2, 0, 1'b0);
        step(1'b1, 8'h02);
        n_rst = 1'b0;
        step(1'b1, 8'h00);
        n_rst = 1'b1;
        clr(); set_in(6, 2, 0, 1'b1);
        step(1'b1, 8'h40);

        // Random traffic with sticky per-input destinations
        clr();
        for (int i = 0; i < NI; i++) dest[i] = int'($urandom_range(NO - 1));
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(9) == 0) dest[i] = int'($urandom_range(NO - 1));
                req[i]         = ($urandom_range(1) == 1);
                req_outport[i] = OW'(dest[i]);
                req_vc[i]      = VW'($urandom_range(NV - 1));
                req_tail[i]    = ($urandom_range(2) == 0);
            end
            for (int o = 0; o < NO; o++)
                for (int v = 0; v < NV; v++)
                    credit_return[o][v] = ($urandom_range(7) == 0);
            step(1'b0, 8'h00);
        end

        clr();
        step(1'b0, 8'h00);
        check("queue_drain", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
